irq_request_latch: RTL
======================

// Module: irq_request_latch
// PURPOSE
//  Upstream front end for the 8:3 priority-encoding path. Captures request events on 8 input lines into a pending
//  register and selects the highest pending index (bit 7 highest, bit 0 lowest). Offers that index downstream over
//  a valid/ready handshake and clears the serviced pending bit on acceptance. Turns level/edge request lines into
//  a stable, one-at-a-time index stream.
// PARAMETERS
//  N_REQ  8  number of request lines (fixed at 8 in this revision; the index width follows from it)
//  IDX_W  3  index width, equal to clog2(N_REQ)
//  EDGE   1  1 = a 0->1 transition on req_in sets pending; 0 = a high level on req_in sets pending every cycle
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  req_in     in   8      raw request lines
//  mask_in    in   8      1 = line not eligible for selection (present only with IRQ_MASK_EN)
//  vec_valid  out  1      vec_idx holds an offered index
//  vec_ready  in   1      consumer accepts the offer when vec_valid && vec_ready
//  vec_idx    out  3      offered index, highest eligible pending bit
//  pending    out  8      current pending register
//  overflow   out  1      one-cycle pulse: a set event hit a bit already pending and not cleared that cycle
// BEHAVIOUR
//  - Reset (clk edge with rst=1): pending=0, req_q=0, vec_valid=0, vec_idx=0, overflow=0, state=IDLE.
//    rst has priority over every other event. Reset mid-offer drops the offer and all pending bits.
//  - set = EDGE ? (req_in & ~req_q) : req_in. req_q <= req_in every cycle.
//    A line held high through reset counts as a new edge on the first cycle after reset.
//  - clr = one-hot(vec_idx) when vec_valid && vec_ready, else 0.
//  - pending <= (pending & ~clr) | set. Set wins over clear on the same bit, so no event is lost.
//  - overflow <= |(set & pending & ~clr).
//  - eligible = pending (or pending & ~mask_in with IRQ_MASK_EN). sel = index of highest set bit of eligible.
//  - FSM, 2 states:
//    IDLE:  if |eligible: vec_idx <= sel, vec_valid <= 1, go to OFFER; else stay in IDLE.
//    OFFER: vec_idx/vec_valid are held stable with no re-arbitration, even if a higher line arrives.
//           On vec_valid && vec_ready: vec_valid <= 0, go to IDLE.
//  - Latency: a req_in rise sampled at edge k sets pending at k. vec_valid is high after edge k+1.
//  - After an accept there is exactly one idle cycle (vec_valid=0) before the next offer.
//  - Throughput: at most 1 index per 2 cycles.
//  - Index widths are exact (3 bits). There is no wrap-around. With eligible=0 the FSM stays in IDLE and vec_idx
//    holds its last value.
// CONFIGURATION
//  - IRQ_MASK_EN defined: the mask_in port exists.
//    Masked bits still latch into pending and still raise overflow, but are never selected.
//    A mask change during OFFER does not withdraw or alter the current offer.
//  - IRQ_MASK_EN undefined: there is no mask_in port and eligible = pending.
// STRUCTURE
//  - Package irq_pkg: N_REQ, IDX_W, FSM state encoding (IDLE=1'b0, OFFER=1'b1).
//  - Sub-module irq_prio_select: combinational 8-bit eligible -> {any, 3-bit highest index}.
//    The top level holds req_q, pending, the FSM and the output registers.
// TESTING
//  1. Hold rst=1 for 2 cycles with req_in=0xFF -> pending=0, vec_valid=0, vec_idx=0, overflow=0.
//     Release rst -> pending=0xFF the next cycle.
//  2. req_in=0x24 pulsed for one cycle, vec_ready=1 -> vec_idx=5 offered and accepted.
//     pending=0x04, one idle cycle, then vec_idx=2.
//  3. vec_ready=0 while offering idx 2, then a rise on req_in[7] -> vec_idx stays 2 and pending=0x84.
//     Raise vec_ready -> next offer is 7.
//  4. Bit 3 offered, vec_ready=1 and a new edge on req_in[3] in the same cycle -> pending[3] stays 1 and overflow=0.
//     Index 3 is re-offered.
//  5. Bit 1 pending, vec_ready=0, a second edge on req_in[1] -> overflow=1 for exactly one cycle.
//     pending is unchanged.
//  6. IRQ_MASK_EN with mask_in=0x80 and req_in edge 0x81 -> offer idx 0.
//     Accept, then mask_in=0x00 -> offer idx 7.
//     Also: rst asserted during OFFER -> vec_valid=0 and pending=0 on the next cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and FSM encoding for the request latch / priority-select slice.
package irq_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic {
    StIdle  = 1'b0,
    StOffer = 1'b1
  } state_e;

endpackage

// File: rtl/irq_request_latch_if.sv
// Downstream index handshake: producer offers vec_idx with vec_valid, consumer answers vec_ready.
interface irq_request_latch_if
  import irq_pkg::*;
();

  logic             vec_valid;
  logic             vec_ready;
  logic [IDX_W-1:0] vec_idx;

  modport master (
    output vec_valid,
    output vec_idx,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_idx,
    output vec_ready
  );

endinterface

// File: rtl/irq_prio_select.sv
// Combinational highest-index selector: bit N_REQ-1 wins, bit 0 loses.
module irq_prio_select
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] eligible_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    any_o = |eligible_i;
    idx_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (eligible_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_request_latch.sv
// Request latch: captures level/edge requests into a pending register and offers the
// highest eligible index over a valid/ready handshake, one index at a time.
// Optional feature: define IRQ_MASK_EN to add the mask_in port (masked lines latch but
// are never selected).
module irq_request_latch
  import irq_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_in,
`ifdef IRQ_MASK_EN
  input  logic [N_REQ-1:0]     mask_in,
`endif
  irq_request_latch_if.master  vec,
  output logic [N_REQ-1:0]     pending,
  output logic                 overflow
);

  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [N_REQ-1:0] set, clr, eligible;
  logic [IDX_W-1:0] idx_q, idx_d, sel;
  logic             any;
  state_e           state_q, state_d;

`ifdef IRQ_MASK_EN
  assign eligible = pending_q & ~mask_in;
`else
  assign eligible = pending_q;
`endif

  irq_prio_select u_prio (
    .eligible_i (eligible),
    .any_o      (any),
    .idx_o      (sel)
  );

  // Set/clear of the pending register; set wins so a re-arriving event is never lost.
  always_comb begin
    set = EDGE ? (req_in & ~req_q) : req_in;
    clr = '0;
    if (vec.vec_valid && vec.vec_ready) clr[idx_q] = 1'b1;
    pending_d  = (pending_q & ~clr) | set;
    overflow_d = |(set & pending_q & ~clr);
  end

  // Offer FSM: the offered index is frozen until accepted, no re-arbitration in StOffer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          idx_d   = sel;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (vec.vec_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, synchronous reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      idx_q      <= '0;
      state_q    <= StIdle;
    end else begin
      req_q      <= req_in;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
    end
  end

  assign vec.vec_valid = (state_q == StOffer);
  assign vec.vec_idx   = idx_q;
  assign pending       = pending_q;
  assign overflow      = overflow_q;

endmodule
